// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus and decoded-instruction handshake of the fetch unit.
interface instruction_fetch_if;
    logic [15:0]  Address;
    logic         nRead;
    logic [255:0] InstrData;
    logic         InstrValid;
    logic         InstrReady;
    logic [7:0]   Opcode;
    logic [7:0]   Dest;
    logic [7:0]   Src1;
    logic [7:0]   Src2;
    logic [11:0]  Pc;

    modport master (
        output Address, nRead, InstrValid, Opcode, Dest, Src1, Src2, Pc,
        input  InstrData, InstrReady
    );
    modport slave (
        input  Address, nRead, InstrValid, Opcode, Dest, Src1, Src2, Pc,
        output InstrData, InstrReady
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch FSM (IDLE/REQ/WAIT/ISSUE/HALT), all outputs registered.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer filled while ISSUE stalls.
module instruction_fetch #(
    parameter logic [3:0] INSTR_SELECT = 4'h1,
    parameter int         MEM_DEPTH    = 10,
    parameter logic [7:0] STOP_OPCODE  = 8'hFF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [11:0]                StartPC,
    output logic                       Busy,
    output logic                       Halted,
    output logic                       FetchErr,
    instruction_fetch_if.master        bus
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT} state_e;

    localparam logic [12:0] DEPTH = 13'(MEM_DEPTH);

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic        nread_q, nread_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic [31:0] rd_word;
    logic [12:0] pc_inc;
    logic        last, hs, start_oob;
    logic        unused_data;

    assign rd_word     = bus.InstrData[31:0];
    assign unused_data = ^bus.InstrData[255:32];
    assign pc_inc      = {1'b0, pc_q} + 13'd1;
    assign last        = (pc_inc == DEPTH);
    assign hs          = valid_q && bus.InstrReady;
    assign start_oob   = ({1'b0, StartPC} >= DEPTH);

`ifdef FETCH_PREFETCH_EN
    typedef enum logic [1:0] {PF_EMPTY, PF_REQ, PF_WAIT, PF_FULL} pf_e;
    pf_e         pf_q, pf_d;
    logic [31:0] buf_q, buf_d;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = 16'h0000;
        nread_d  = 1'b1;
        valid_d  = valid_q;
        instr_d  = instr_q;
        err_d    = err_q;
`ifdef FETCH_PREFETCH_EN
        pf_d     = pf_q;
        buf_d    = buf_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    err_d = 1'b0;
                    pc_d  = StartPC;
                    if (start_oob) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        nread_d = 1'b0;
                        addr_d  = {INSTR_SELECT, StartPC};
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                instr_d = rd_word;
                if (rd_word[31:24] == STOP_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (hs && last) begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else if (hs) begin
                    pc_d    = pc_inc[11:0];
                    valid_d = 1'b0;
                    state_d = S_REQ;
                    nread_d = 1'b0;
                    addr_d  = {INSTR_SELECT, pc_inc[11:0]};
`ifdef FETCH_PREFETCH_EN
                    pf_d = PF_EMPTY;
                    case (pf_q)
                        PF_REQ: begin
                            // Read already issued; its data arrives next cycle as in WAIT.
                            state_d = S_WAIT;
                            nread_d = 1'b1;
                            addr_d  = 16'h0000;
                        end
                        PF_WAIT, PF_FULL: begin
                            nread_d = 1'b1;
                            addr_d  = 16'h0000;
                            instr_d = (pf_q == PF_FULL) ? buf_q : rd_word;
                            if (instr_d[31:24] == STOP_OPCODE) begin
                                state_d = S_HALT;
                            end else begin
                                state_d = S_ISSUE;
                                valid_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (pf_q)
                        PF_EMPTY: if (!last) begin
                            pf_d    = PF_REQ;
                            nread_d = 1'b0;
                            addr_d  = {INSTR_SELECT, pc_inc[11:0]};
                        end
                        PF_REQ:  pf_d = PF_WAIT;
                        PF_WAIT: begin
                            pf_d  = PF_FULL;
                            buf_d = rd_word;
                        end
                        default: ;
                    endcase
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= 12'h000;
            addr_q   <= 16'h0000;
            nread_q  <= 1'b1;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            nread_q  <= nread_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

`ifdef FETCH_PREFETCH_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pf_q  <= PF_EMPTY;
            buf_q <= 32'h0;
        end else begin
            pf_q  <= pf_d;
            buf_q <= buf_d;
        end
    end
`endif

    assign bus.Address    = addr_q;
    assign bus.nRead      = nread_q;
    assign bus.InstrValid = valid_q;
    assign bus.Opcode     = instr_q[31:24];
    assign bus.Dest       = instr_q[23:16];
    assign bus.Src1       = instr_q[15:8];
    assign bus.Src2       = instr_q[7:0];
    assign bus.Pc         = pc_q;
    assign Busy           = busy_q;
    assign Halted         = halted_q;
    assign FetchErr       = err_q;
endmodule
